// File: rtl/down_cnt_reload_if.sv
// Control/status bundle for the programmable down-counter timer.
// The master drives commands and the period; the slave returns count, carry and busy.
interface down_cnt_reload_if #(
  parameter int unsigned W = 12
);
  logic         CE;
  logic         LOAD;
  logic [W-1:0] LOAD_VAL;
  logic         START;
  logic         STOP;
  logic         ONESHOT;
  logic [W-1:0] Q;
  logic         CO;
  logic         BUSY;

  modport master (
    output CE, LOAD, LOAD_VAL, START, STOP, ONESHOT,
    input  Q, CO, BUSY
  );

  modport slave (
    input  CE, LOAD, LOAD_VAL, START, STOP, ONESHOT,
    output Q, CO, BUSY
  );
endinterface

// File: rtl/down_cnt_reload.sv
// Programmable down-counter/timer with runtime period, periodic or one-shot mode,
// and a carry pulse on the CE tick where the count sits at zero.
module down_cnt_reload #(
  parameter int unsigned W            = 12,
  parameter int unsigned DEFAULT_LOAD = 3199
) (
  input  logic                  CLK,
  input  logic                  CLR,
  down_cnt_reload_if.slave      bus
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [W-1:0] ZERO_W = {W{1'b0}};
  localparam logic [W-1:0] ONE_W  = {{(W-1){1'b0}}, 1'b1};

  state_t       state_r;
  logic [W-1:0] q_r;
  logic [W-1:0] period_r;
  logic         mode_r;
  logic         busy_r;
  logic [W-1:0] eff_period_s;
  logic         at_zero_s;

  // A same-cycle LOAD bypasses into any START or reload happening in that cycle.
  assign eff_period_s = bus.LOAD ? bus.LOAD_VAL : period_r;
  assign at_zero_s    = (q_r == ZERO_W);

  assign bus.Q    = q_r;
  assign bus.BUSY = busy_r;
  assign bus.CO   = bus.CE & (state_r == ST_RUN) & at_zero_s & ~bus.STOP & ~bus.START;

  // Counter FSM: CLR first, then STOP > START > counting; LOAD updates the period regardless.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      state_r  <= ST_IDLE;
      q_r      <= ZERO_W;
      period_r <= W'(DEFAULT_LOAD);
      mode_r   <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      if (bus.LOAD) begin
        period_r <= bus.LOAD_VAL;
      end
      if (bus.STOP) begin
        state_r <= ST_IDLE;
        busy_r  <= 1'b0;
      end else if (bus.START) begin
        q_r     <= eff_period_s;
        mode_r  <= bus.ONESHOT;
        state_r <= ST_RUN;
        busy_r  <= 1'b1;
      end else begin
        case (state_r)
          ST_RUN: begin
            if (bus.CE) begin
              if (!at_zero_s) begin
                q_r <= q_r - ONE_W;
              end else if (mode_r) begin
                state_r <= ST_IDLE;
                busy_r  <= 1'b0;
              end else begin
                q_r <= eff_period_s;
              end
            end
          end
          ST_IDLE: begin
            busy_r <= 1'b0;
          end
          default: begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_down_cnt_reload.sv
// Self-checking bench: directed vector table, multi-cycle corner sequences,
// and randomized traffic compared against an interval-based reference model.
module tb_down_cnt_reload;

  localparam int unsigned W = 12;

  logic CLK;
  logic CLR;
  int   n_cmp;
  int   n_bad;

  down_cnt_reload_if #(.W(W)) bus ();

  down_cnt_reload #(.W(W), .DEFAULT_LOAD(3199)) dut (
    .CLK (CLK),
    .CLR (CLR),
    .bus (bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference model: an interval starts with value base; ticks counts CE ticks consumed.
  bit m_ok;
  bit m_run;
  bit m_one;
  int m_period;
  int m_base;
  int m_ticks;

  typedef struct {
    logic        clr;
    logic        ce;
    logic        load;
    logic [11:0] val;
    logic        start;
    logic        stop;
    logic        oneshot;
    logic        exp_co;
    logic [11:0] exp_q;
    logic        exp_busy;
  } vec_t;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic model_update(input logic c, e, l, input logic [11:0] v, input logic s, p, o);
    int eff;
    if (c) begin
      m_ok = 1'b1; m_run = 1'b0; m_one = 1'b0;
      m_period = 3199; m_base = 0; m_ticks = 0;
    end else begin
      eff = l ? int'(v) : m_period;
      if (l) m_period = int'(v);
      if (p) begin
        m_run = 1'b0;
      end else if (s) begin
        m_base = eff; m_ticks = 0; m_run = 1'b1; m_one = o;
      end else if (m_run && e) begin
        if (m_ticks < m_base) m_ticks++;
        else if (m_one) m_run = 1'b0;
        else begin m_base = eff; m_ticks = 0; end
      end
    end
  endtask

  // One clock: drive at negedge, check CO before the edge, Q/BUSY after it.
  task automatic step(input logic c, e, l, input logic [11:0] v, input logic s, p, o,
                      output logic g_co, output logic [11:0] g_q, output logic g_busy);
    logic exp_co;
    CLR = c; bus.CE = e; bus.LOAD = l; bus.LOAD_VAL = v;
    bus.START = s; bus.STOP = p; bus.ONESHOT = o;
    #1;
    exp_co = m_run && e && !s && !p && (m_ticks == m_base);
    g_co = bus.CO;
    if (m_ok) check("model_co", {31'd0, g_co}, {31'd0, exp_co});
    @(posedge CLK);
    model_update(c, e, l, v, s, p, o);
    #1;
    g_q = bus.Q; g_busy = bus.BUSY;
    check("model_q", {20'd0, g_q}, 32'(m_base - m_ticks));
    check("model_busy", {31'd0, g_busy}, {31'd0, m_run});
    @(negedge CLK);
  endtask

  task automatic tick(input logic e, l, input logic [11:0] v, input logic s, p, o, output logic g_co);
    logic [11:0] gq;
    logic gb;
    step(1'b0, e, l, v, s, p, o, g_co, gq, gb);
  endtask

  initial begin
    vec_t        tbl[$];
    logic        gco;
    logic [11:0] gq;
    logic        gb;
    int          ce_cnt;

    n_cmp = 0; n_bad = 0; m_ok = 1'b0;
    m_run = 1'b0; m_one = 1'b0; m_period = 0; m_base = 0; m_ticks = 0;
    CLR = 1'b1; bus.CE = 1'b0; bus.LOAD = 1'b0; bus.LOAD_VAL = 12'd0;
    bus.START = 1'b0; bus.STOP = 1'b0; bus.ONESHOT = 1'b0;
    @(negedge CLK);
    step(1'b1, 1'b0, 1'b0, 12'd0, 1'b0, 1'b0, 1'b0, gco, gq, gb);

    //          clr   ce    load  val      start stop  one   co    q          busy
    tbl.push_back('{1'b1, 1'b1, 1'b0, 12'd0, 1'b0, 1'b0, 1'b0, 1'b0, 12'd0,    1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 12'd4, 1'b0, 1'b0, 1'b0, 1'b0, 12'd0,    1'b0});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 12'd0, 1'b1, 1'b0, 1'b1, 1'b0, 12'd4,    1'b1});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 12'd0, 1'b0, 1'b0, 1'b0, 1'b0, 12'd3,    1'b1});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 12'd0, 1'b0, 1'b0, 1'b0, 1'b0, 12'd2,    1'b1});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 12'd0, 1'b0, 1'b0, 1'b0, 1'b0, 12'd1,    1'b1});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 12'd0, 1'b0, 1'b0, 1'b0, 1'b0, 12'd0,    1'b1});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 12'd0, 1'b0, 1'b0, 1'b0, 1'b1, 12'd0,    1'b0});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 12'd0, 1'b0, 1'b0, 1'b0, 1'b0, 12'd0,    1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 12'd7, 1'b1, 1'b0, 1'b0, 1'b0, 12'd7,    1'b1});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 12'd0, 1'b0, 1'b0, 1'b0, 1'b0, 12'd7,    1'b1});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 12'd0, 1'b0, 1'b0, 1'b0, 1'b0, 12'd6,    1'b1});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 12'd0, 1'b0, 1'b0, 1'b0, 1'b0, 12'd5,    1'b1});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 12'd0, 1'b1, 1'b1, 1'b0, 1'b0, 12'd5,    1'b0});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 12'd0, 1'b0, 1'b0, 1'b0, 1'b0, 12'd5,    1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 12'd0, 1'b1, 1'b0, 1'b0, 1'b0, 12'd7,    1'b1});
    tbl.push_back('{1'b0, 1'b1, 1'b1, 12'd0, 1'b1, 1'b0, 1'b0, 1'b0, 12'd0,    1'b1});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 12'd0, 1'b0, 1'b0, 1'b0, 1'b1, 12'd0,    1'b1});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 12'd0, 1'b0, 1'b0, 1'b0, 1'b1, 12'd0,    1'b1});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 12'd0, 1'b0, 1'b0, 1'b0, 1'b0, 12'd0,    1'b1});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 12'd0, 1'b0, 1'b1, 1'b0, 1'b0, 12'd0,    1'b0});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 12'd0, 1'b1, 1'b0, 1'b0, 1'b0, 12'd0,    1'b1});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 12'd0, 1'b0, 1'b0, 1'b0, 1'b1, 12'd0,    1'b0});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 12'd0, 1'b1, 1'b0, 1'b0, 1'b0, 12'd3199, 1'b1});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 12'd0, 1'b0, 1'b1, 1'b0, 1'b0, 12'd3199, 1'b0});

    foreach (tbl[i]) begin
      step(tbl[i].clr, tbl[i].ce, tbl[i].load, tbl[i].val, tbl[i].start, tbl[i].stop,
           tbl[i].oneshot, gco, gq, gb);
      check($sformatf("tbl%0d_co", i), {31'd0, gco}, {31'd0, tbl[i].exp_co});
      check($sformatf("tbl%0d_q", i), {20'd0, gq}, {20'd0, tbl[i].exp_q});
      check($sformatf("tbl%0d_busy", i), {31'd0, gb}, {31'd0, tbl[i].exp_busy});
    end

    // Default period, periodic: CO every 3200 CE ticks.
    step(1'b1, 1'b0, 1'b0, 12'd0, 1'b0, 1'b0, 1'b0, gco, gq, gb);
    tick(1'b1, 1'b0, 12'd0, 1'b1, 1'b0, 1'b0, gco);
    for (int t = 1; t <= 6405; t++) begin
      tick(1'b1, 1'b0, 12'd0, 1'b0, 1'b0, 1'b0, gco);
      check($sformatf("dflt_co_t%0d", t), {31'd0, gco}, {31'd0, (t % 3200) == 0});
    end

    // Period 9, rewritten to 2 mid-interval: CO at tick 10, then every 3.
    tick(1'b1, 1'b1, 12'd9, 1'b1, 1'b0, 1'b0, gco);
    for (int t = 1; t <= 22; t++) begin
      tick(1'b1, (t == 4), 12'd2, 1'b0, 1'b0, 1'b0, gco);
      check($sformatf("midload_co_t%0d", t), {31'd0, gco},
            {31'd0, (t == 10) || (t > 10 && ((t - 10) % 3) == 0)});
    end

    // CE toggling with period 3: CO every 8 clocks, only on CE=1.
    tick(1'b0, 1'b1, 12'd3, 1'b1, 1'b0, 1'b0, gco);
    for (int c = 1; c <= 40; c++) begin
      tick((c % 2) == 1, 1'b0, 12'd0, 1'b0, 1'b0, 1'b0, gco);
      check($sformatf("toggle_co_c%0d", c), {31'd0, gco}, {31'd0, (c % 8) == 7});
    end

    // Randomized traffic against the model.
    ce_cnt = 0;
    for (int n = 0; n < 4000; n++) begin
      logic [11:0] rv;
      rv = ($urandom_range(0, 7) == 0) ? 12'($urandom) : 12'($urandom_range(0, 12));
      step($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0,
           rv, $urandom_range(0, 14) == 0, $urandom_range(0, 29) == 0, 1'($urandom),
           gco, gq, gb);
      if (gco) ce_cnt++;
    end
    if (ce_cnt == 0) $display("note: random phase produced no carry pulses");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
